logic_unit_seq: RTL and testbench



---
 rtl/logic_unit_seq_pkg.sv | 15 +
 rtl/logic_unit_seq_if.sv | 26 ++
 rtl/logic_unit_seq_slice.sv | 24 ++
 rtl/logic_unit_seq.sv | 112 +++++++++++
 tb/tb_logic_unit_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_seq_pkg.sv
// Shared op encodings and FSM state type for the sliced bitwise logic unit.
package logic_unit_seq_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_unit_seq_if.sv
// Operand/result bundle: input valid/ready channel plus held result with output valid/ready.
interface logic_unit_seq_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/logic_unit_seq_slice.sv
// Combinational AND/OR/XOR/NOR over one SLICE-bit chunk of the operands.
module logic_unit_seq_slice
  import logic_unit_seq_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [1:0]       op_i,
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic [SLICE-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: captures operands, evaluates SLICE bits per cycle,
// then holds result and zero flag until the consumer takes them.
module logic_unit_seq
  import logic_unit_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic             clk,
  input logic             rst_n,
  logic_unit_seq_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("logic_unit_seq: SLICE must divide WIDTH");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             accept;
  logic             busy;
  logic             last_slice;

  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];
  logic [SLICE-1:0] y_sl;

  assign accept     = bus.in_valid && (state_q == IDLE);
  assign busy       = (state_q == BUSY);
  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  // One shared slice evaluator; cnt selects which chunk feeds it and which chunk it writes.
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign a_sl[gi] = a_q[gi*SLICE +: SLICE];
    assign b_sl[gi] = b_q[gi*SLICE +: SLICE];
    assign result_d[gi*SLICE +: SLICE] =
      (busy && (cnt_q == CW'(gi))) ? y_sl : result_q[gi*SLICE +: SLICE];
  end

  logic_unit_seq_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .op_i (op_q),
    .a_i  (a_sl[cnt_q]),
    .b_i  (b_sl[cnt_q]),
    .y_o  (y_sl)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (last_slice) begin
          state_d = DONE;
          // result_d already carries the final slice written on this edge.
          zero_d  = (result_d == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench: a 32/8 unit and a 16/16 unit driven through their interfaces.
module tb_logic_unit_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic_unit_seq_if #(.WIDTH(32)) bus0 ();
  logic_unit_seq_if #(.WIDTH(16)) bus1 ();

  logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  logic_unit_seq #(.WIDTH(16), .SLICE(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Full operation on the 32/8 unit with latency, result and zero checks.
  task automatic do_op0(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ez);
    int n;
    bus0.op = op;
    bus0.a = a;
    bus0.b = b;
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    n = 0;
    while (bus0.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_res"}, bus0.result, er);
    chk({tag, "_zero"}, {31'd0, bus0.zero}, {31'd0, ez});
    $display("op %s op=%0d a=%08h b=%08h result=%08h zero=%0b", tag, op, a, b,
             bus0.result, bus0.zero);
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    chk({tag, "_ovld_clr"}, {31'd0, bus0.out_valid}, 32'd0);
  endtask

  initial begin
    int hs;
    int hv;
    logic [31:0] r_hold;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.op = 2'b00; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.op = 2'b00; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;

    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_result", bus0.result, 32'd0);
    chk("rst_zero", {31'd0, bus0.zero}, 32'd0);
    chk("rst_ovld", {31'd0, bus0.out_valid}, 32'd0);
    chk("rst_irdy", {31'd0, bus0.in_ready}, 32'd1);
    chk("rst_irdy1", {31'd0, bus1.in_ready}, 32'd1);
    $display("reset released");

    // NOR with cycle-exact latency
    bus0.op = 2'b11; bus0.a = 32'h0000_0000; bus0.b = 32'h0000_00FF; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    bus0.a = 32'hFFFF_FFFF;
    chk("nor_irdy_busy", {31'd0, bus0.in_ready}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("nor_ovld_k", {31'd0, bus0.out_valid}, (k == 4) ? 32'd1 : 32'd0);
    end
    chk("nor_res", bus0.result, 32'hFFFF_FF00);
    chk("nor_zero", {31'd0, bus0.zero}, 32'd0);
    $display("op nor a=00000000 b=000000ff result=%08h zero=%0b", bus0.result, bus0.zero);
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    chk("nor_ovld_clr", {31'd0, bus0.out_valid}, 32'd0);
    chk("nor_irdy_back", {31'd0, bus0.in_ready}, 32'd1);

    do_op0("or", 2'b01, 32'hF000_000F, 32'h0000_F0F0, 32'hF000_F0FF, 1'b0);
    do_op0("nor0", 2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op0("and", 2'b00, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 32'h0505_5050, 1'b0);

    // XOR to zero, then back-pressure
    bus0.op = 2'b10; bus0.a = 32'hDEAD_BEEF; bus0.b = 32'hDEAD_BEEF; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    repeat (4) tick();
    chk("xor_ovld", {31'd0, bus0.out_valid}, 32'd1);
    chk("xor_res", bus0.result, 32'd0);
    chk("xor_zero", {31'd0, bus0.zero}, 32'd1);
    $display("op xor a=deadbeef b=deadbeef result=%08h zero=%0b", bus0.result, bus0.zero);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_res", bus0.result, 32'd0);
      chk("bp_zero", {31'd0, bus0.zero}, 32'd1);
      chk("bp_ovld", {31'd0, bus0.out_valid}, 32'd1);
      chk("bp_irdy", {31'd0, bus0.in_ready}, 32'd0);
    end
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    chk("bp_ovld_clr", {31'd0, bus0.out_valid}, 32'd0);

    // Operand churn and in_valid pulses while busy
    bus0.op = 2'b00; bus0.a = 32'h1234_5678; bus0.b = 32'h0F0F_0F0F; bus0.in_valid = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus0.a = $urandom;
      bus0.b = $urandom;
      bus0.op = 2'($urandom_range(0, 3));
      bus0.in_valid = k[0];
      tick();
    end
    bus0.in_valid = 1'b0;
    chk("mid_ovld", {31'd0, bus0.out_valid}, 32'd1);
    chk("mid_res", bus0.result, 32'h0204_0608);
    $display("op mid-change captured a=12345678 b=0f0f0f0f result=%08h", bus0.result);
    hs = 0;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (bus0.out_valid && bus0.out_ready) hs++;
      tick();
    end
    bus0.out_ready = 1'b0;
    chk("mid_handshakes", hs, 1);

    // Reset during the second BUSY cycle
    bus0.op = 2'b00; bus0.a = 32'hFFFF_FFFF; bus0.b = 32'hFFFF_FFFF; bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rmid_irdy", {31'd0, bus0.in_ready}, 32'd1);
    chk("rmid_res", bus0.result, 32'd0);
    chk("rmid_zero", {31'd0, bus0.zero}, 32'd0);
    hv = 0;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus0.out_valid) hv++;
    end
    bus0.out_ready = 1'b0;
    chk("rmid_no_ovld", hv, 0);
    $display("op aborted by reset");
    do_op0("xor_after_rst", 2'b10, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);

    // Single-slice build: AND then an immediately queued XOR
    bus1.op = 2'b00; bus1.a = 16'hF0F0; bus1.b = 16'h3C3C; bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    chk("w16_ovld_e0", {31'd0, bus1.out_valid}, 32'd0);
    tick();
    chk("w16_ovld_e1", {31'd0, bus1.out_valid}, 32'd1);
    chk("w16_res", {16'd0, bus1.result}, 32'h0000_3030);
    chk("w16_zero", {31'd0, bus1.zero}, 32'd0);
    $display("op w16 and a=f0f0 b=3c3c result=%04h zero=%0b", bus1.result, bus1.zero);
    r_hold = {16'd0, bus1.result};
    bus1.out_ready = 1'b1;
    bus1.op = 2'b10; bus1.a = 16'hFFFF; bus1.b = 16'h00FF; bus1.in_valid = 1'b1;
    tick();
    chk("b2b_irdy", {31'd0, bus1.in_ready}, 32'd1);
    chk("b2b_ovld_clr", {31'd0, bus1.out_valid}, 32'd0);
    chk("b2b_res_kept", {16'd0, bus1.result}, r_hold);
    tick();
    bus1.in_valid = 1'b0;
    chk("b2b_accepted", {31'd0, bus1.in_ready}, 32'd0);
    tick();
    chk("b2b_ovld", {31'd0, bus1.out_valid}, 32'd1);
    chk("b2b_res", {16'd0, bus1.result}, 32'h0000_FF00);
    $display("op w16 xor a=ffff b=00ff result=%04h zero=%0b", bus1.result, bus1.zero);
    tick();
    bus1.out_ready = 1'b0;
    chk("b2b_done", {31'd0, bus1.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
